// File: rtl/ref_mem_array.sv
// 32-bank reference-frame buffer: per-bank write ports and a two-stage read
// pipeline (SRAM read, then bank rotation into the output register).
module ref_mem_array #(
   parameter int NBANK    = 32,
   parameter int AW       = 7,
   parameter int DW       = 8,
   parameter int ROT_STEP = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NBANK-1:0]      Bank_sel,
   input  logic [AW*NBANK-1:0]   write_address_all,
   input  logic [DW*NBANK-1:0]   wr_data,
   input  logic [AW*NBANK-1:0]   rd_address_all,
   input  logic                  rd8R_en,
   input  logic [3:0]            rdR_sel,
   output logic [DW*NBANK-1:0]   ref_data,
   output logic                  ref_valid
);

   localparam int DEPTH = 1 << AW;

   logic [DW*NBANK-1:0] s1_data;
   logic                s1_valid;
   logic [3:0]          s1_rot;
   logic [5:0]          offset;
   logic [DW*NBANK-1:0] rot_data;

   // Each bank reads its old contents on a same-address write (read-before-write).
   for (genvar i = 0; i < NBANK; i++) begin : g_bank
      logic [DW-1:0] mem [DEPTH];
      logic [DW-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (Bank_sel[i])
            mem[write_address_all[AW*i +: AW]] <= wr_data[DW*i +: DW];
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            rd_q <= '0;
         else if (!rd8R_en)
            rd_q <= mem[rd_address_all[AW*i +: AW]];
      end

      assign s1_data[DW*i +: DW] = rd_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_rot   <= '0;
      end else begin
         s1_valid <= ~rd8R_en;
         if (!rd8R_en)
            s1_rot <= rdR_sel;
      end
   end

   assign offset = 6'(int'(s1_rot) * ROT_STEP);

   always_comb begin
      rot_data = '0;
      for (int j = 0; j < NBANK; j++)
         rot_data[DW*j +: DW] = s1_data[DW*((j + int'(offset)) % NBANK) +: DW];
   end

   // Output holds its last value across stalls so the PE array can reuse it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_data  <= '0;
         ref_valid <= 1'b0;
      end else begin
         ref_valid <= s1_valid;
         if (s1_valid)
            ref_data <= rot_data;
      end
   end

endmodule

// File: tb/tb_ref_mem_array.sv
// Directed bench for ref_mem_array: table of rotated reads plus hand-written
// sequences for stalls, read/write collision, partial writes and mid-read reset.
module tb_ref_mem_array;

   localparam int NBANK = 32;
   localparam int AW    = 7;
   localparam int DW    = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NBANK-1:0]    Bank_sel;
   logic [AW*NBANK-1:0] write_address_all;
   logic [DW*NBANK-1:0] wr_data;
   logic [AW*NBANK-1:0] rd_address_all;
   logic                rd8R_en;
   logic [3:0]          rdR_sel;
   logic [DW*NBANK-1:0] ref_data;
   logic                ref_valid;

   typedef struct {
      int         row;
      int         rot;
      logic [7:0] exp_s0;
      logic [7:0] exp_s31;
   } rd_vec_t;

   rd_vec_t vecs [6];
   int n_vec  = 0;
   int n_miss = 0;

   ref_mem_array dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .Bank_sel          (Bank_sel),
      .write_address_all (write_address_all),
      .wr_data           (wr_data),
      .rd_address_all    (rd_address_all),
      .rd8R_en           (rd8R_en),
      .rdR_sel           (rdR_sel),
      .ref_data          (ref_data),
      .ref_valid         (ref_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [AW*NBANK-1:0] bcast_addr(input int row);
      logic [AW*NBANK-1:0] v;
      for (int i = 0; i < NBANK; i++)
         v[AW*i +: AW] = AW'(row);
      return v;
   endfunction

   // Preload pattern: bank i row r holds (i*4 + r) & 0xFF.
   function automatic logic [DW*NBANK-1:0] preload_row(input int row);
      logic [DW*NBANK-1:0] v;
      for (int i = 0; i < NBANK; i++)
         v[DW*i +: DW] = 8'((i * 4 + row) & 255);
      return v;
   endfunction

   function automatic logic [DW*NBANK-1:0] exp_vec(input int row, input int rot);
      logic [DW*NBANK-1:0] v;
      int b;
      for (int j = 0; j < NBANK; j++) begin
         b = (j + rot * 2) % NBANK;
         v[DW*j +: DW] = 8'((b * 4 + row) & 255);
      end
      return v;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NBANK-1:0] sel, input int wrow,
                                input logic [DW*NBANK-1:0] wdata, input int rrow,
                                input logic en, input int rot);
      Bank_sel          = sel;
      write_address_all = bcast_addr(wrow);
      wr_data           = wdata;
      rd_address_all    = bcast_addr(rrow);
      rd8R_en           = en;
      rdR_sel           = 4'(rot);
   endtask

   task automatic idle;
      applyStimulus('0, 0, '0, 0, 1'b1, 0);
   endtask

   task automatic checkOutput(input string name, input logic [DW*NBANK-1:0] act,
                              input logic [DW*NBANK-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   initial begin
      logic [DW*NBANK-1:0] d;

      vecs[0] = '{2,  0, 8'h02, 8'h7E};
      vecs[1] = '{0,  3, 8'h18, 8'h14};
      vecs[2] = '{0, 15, 8'h78, 8'h74};
      vecs[3] = '{1,  1, 8'h09, 8'h05};
      vecs[4] = '{3,  8, 8'h43, 8'h3F};
      vecs[5] = '{0,  0, 8'h00, 8'h7C};

      rst_n = 1'b0;
      idle();
      repeat (2) tick();
      checkOutput("reset_valid", {255'd0, ref_valid}, '0);
      checkOutput("reset_data", ref_data, '0);
      rst_n = 1'b1;
      tick();

      // Preload rows 0..3 and 9 on every bank, plus bank 7 row 5 = 0xAA.
      foreach (vecs[k]) begin end
      for (int r = 0; r < 4; r++) begin
         applyStimulus('1, r, preload_row(r), 0, 1'b1, 0);
         tick();
      end
      applyStimulus('1, 9, preload_row(9), 0, 1'b1, 0);
      tick();
      d = '0;
      d[DW*7 +: DW] = 8'hAA;
      applyStimulus(32'h0000_0080, 5, d, 0, 1'b1, 0);
      tick();
      idle();
      tick();

      for (int k = 0; k < 6; k++) begin
         applyStimulus('0, 0, '0, vecs[k].row, 1'b0, vecs[k].rot);
         tick();
         idle();
         tick();
         checkOutput($sformatf("vec%0d_valid", k), {255'd0, ref_valid}, 256'd1);
         checkOutput($sformatf("vec%0d_slice0", k), {248'd0, ref_data[7:0]}, {248'd0, vecs[k].exp_s0});
         checkOutput($sformatf("vec%0d_slice31", k), {248'd0, ref_data[255:248]}, {248'd0, vecs[k].exp_s31});
         checkOutput($sformatf("vec%0d_data", k), ref_data, exp_vec(vecs[k].row, vecs[k].rot));
      end

      // Stall: reads of rows 0,1, three idle cycles, then row 2.
      applyStimulus('0, 0, '0, 0, 1'b0, 0);
      tick();
      applyStimulus('0, 0, '0, 1, 1'b0, 0);
      tick();
      checkOutput("stall_v1", {255'd0, ref_valid}, 256'd1);
      checkOutput("stall_d1", ref_data, exp_vec(0, 0));
      idle();
      tick();
      checkOutput("stall_v2", {255'd0, ref_valid}, 256'd1);
      checkOutput("stall_d2", ref_data, exp_vec(1, 0));
      tick();
      checkOutput("stall_v3", {255'd0, ref_valid}, 256'd0);
      checkOutput("stall_d3", ref_data, exp_vec(1, 0));
      tick();
      checkOutput("stall_v4", {255'd0, ref_valid}, 256'd0);
      checkOutput("stall_d4", ref_data, exp_vec(1, 0));
      applyStimulus('0, 0, '0, 2, 1'b0, 0);
      tick();
      checkOutput("stall_v5", {255'd0, ref_valid}, 256'd0);
      checkOutput("stall_d5", ref_data, exp_vec(1, 0));
      idle();
      tick();
      checkOutput("stall_v6", {255'd0, ref_valid}, 256'd1);
      checkOutput("stall_d6", ref_data, exp_vec(2, 0));

      // Collision: write 0x55 to bank 7 row 5 while reading it.
      d = '0;
      d[DW*7 +: DW] = 8'h55;
      applyStimulus(32'h0000_0080, 5, d, 5, 1'b0, 0);
      tick();
      applyStimulus('0, 0, '0, 5, 1'b0, 0);
      tick();
      checkOutput("coll_valid", {255'd0, ref_valid}, 256'd1);
      checkOutput("coll_old", {248'd0, ref_data[DW*7 +: DW]}, {248'd0, 8'hAA});
      idle();
      tick();
      checkOutput("coll_new", {248'd0, ref_data[DW*7 +: DW]}, {248'd0, 8'h55});

      // Partial write of 0xEE to row 9, banks 4..7 only.
      applyStimulus(32'h0000_00F0, 9, {32{8'hEE}}, 0, 1'b1, 0);
      tick();
      applyStimulus('0, 0, '0, 9, 1'b0, 0);
      tick();
      idle();
      tick();
      d = preload_row(9);
      for (int i = 4; i < 8; i++)
         d[DW*i +: DW] = 8'hEE;
      checkOutput("partial_valid", {255'd0, ref_valid}, 256'd1);
      checkOutput("partial_data", ref_data, d);

      // Reset in the middle of continuous reads.
      applyStimulus('0, 0, '0, 2, 1'b0, 0);
      repeat (3) tick();
      checkOutput("prerst_valid", {255'd0, ref_valid}, 256'd1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst_async_valid", {255'd0, ref_valid}, 256'd0);
      checkOutput("rst_async_data", ref_data, '0);
      idle();
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("post_rst_idle", {255'd0, ref_valid}, 256'd0);
      applyStimulus('0, 0, '0, 2, 1'b0, 0);
      tick();
      checkOutput("post_rst_s1", {255'd0, ref_valid}, 256'd0);
      idle();
      tick();
      checkOutput("post_rst_valid", {255'd0, ref_valid}, 256'd1);
      checkOutput("post_rst_data", ref_data, exp_vec(2, 0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/ref_mem_array.md
Name: ref_mem_array

Overview:
- 32-bank on-chip reference-frame buffer, directly downstream of the reference memory controller.
- Accepts the controller's per-bank write strobes and addresses, and stores pixel data streamed in during preload.
- Serves per-bank registered reads, realigned by a bank rotation, to the PE array.
- Two-stage read pipeline: stage 1 is the SRAM read; stage 2 is the rotation/output register.

Parameters:
- NBANK, 32, number of banks (fixed by the controller's 32-bit bank select).
- AW, 7, address width per bank (depth 2^AW = 128 rows).
- DW, 8, data width per bank word (one pixel).
- ROT_STEP, 2, banks rotated per unit of rdR_sel.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Bank_sel  in  NBANK  per-bank write enable; bit i writes bank i.
- write_address_all  in  AW*NBANK  bank i write address = bits [AW*i+AW-1 : AW*i].
- wr_data  in  DW*NBANK  bank i write data = bits [DW*i+DW-1 : DW*i].
- rd_address_all  in  AW*NBANK  bank i read address, same slicing as the write address.
- rd8R_en  in  1  read enable, active low (0 = read all banks).
- rdR_sel  in  4  output rotation select.
- ref_data  out  DW*NBANK  rotated read data to the PE array.
- ref_valid  out  1  ref_data updated this cycle.

Behaviour:
- Reset (async assert, sync release):
  - ref_data = 0, ref_valid = 0.
  - Stage-1 data register = 0, stage-1 valid = 0, stage-1 rotation register = 0.
  - Bank contents are not reset; unwritten rows read X in simulation, and the bench must not check them.
- Write:
  - On a clock edge with Bank_sel[i] = 1, bank i at write_address_all slice i gets wr_data slice i.
  - Any subset of banks may write in the same cycle.
  - Writes are independent of rd8R_en.
- Read stage 1 (cycle N, rd8R_en = 0):
  - Each bank registers mem[i][rd_address slice i] into s1_data[i].
  - s1_valid <= 1; s1_rot <= rdR_sel.
  - If rd8R_en = 1: s1_data and s1_rot hold, s1_valid <= 0.
- Read stage 2 (cycle N+1):
  - If s1_valid = 1: ref_data slice j <= s1_data[(j + s1_rot*ROT_STEP) mod NBANK] for j = 0..NBANK-1, and ref_valid <= 1.
  - If s1_valid = 0: ref_data holds its last value and ref_valid <= 0. This hold supports reuse stalls.
- Latency: address presented at edge N produces ref_data valid after edge N+2 (2 cycles). Throughput is one read per cycle.
- Rotation arithmetic:
  - Offset = rdR_sel*ROT_STEP, computed in 6 bits, then mod 32.
  - rdR_sel = 15 with ROT_STEP = 2 gives offset 30.
  - No overflow path exists for default parameters; other parameters take the offset mod NBANK.
- Same-cycle read and write to the same bank and address: read returns the OLD contents (read-before-write). The new data is visible to a read issued one cycle later.
- Simultaneous write to different addresses of the same bank while reading: no interaction.
- Reset mid-read: pipeline outputs clear immediately. On release, the first ref_valid occurs 2 cycles after the first rd8R_en = 0 sample. Memory contents written before reset are retained and readable.
- Address range: full 0..127 is accessible, with no wrap logic. The controller never issues out-of-range addresses because the width is exact.
- No state machine beyond the 2-stage valid pipeline; no backpressure. The consumer must accept ref_data whenever ref_valid = 1.

Test Plan:
1. Preload and read: write bank i row r = (i*4 + r) & 0xFF for r 0..3, i 0..31. Then read row 2 on all banks with rdR_sel = 0. Required: 2 cycles later ref_valid = 1 and slice j = (j*4 + 2) & 0xFF.
2. Rotation: same data, read row 0 with rdR_sel = 3 (offset 6). Required: ref_data slice 0 = bank 6 data (0x18) and slice 31 = bank 5 data (0x14). Then rdR_sel = 15: slice 0 = bank 30 (0x78).
3. Stall hold: issue reads rows 0, 1; hold rd8R_en = 1 for 3 cycles; then read row 2. Required: ref_valid pattern 1,1,0,0,0,1, with ref_data frozen at the row-1 value during the zeros.
4. Read/write collision: bank 7 row 5 = 0xAA; in the same cycle write 0x55 and read row 5. Required: returned data 0xAA. A read on the next cycle returns 0x55.
5. Partial bank write: Bank_sel = 0x000000F0 writing 0xEE to row 9 everywhere. Required: a read of row 9 shows 0xEE only in banks 4..7; other banks are unchanged.
6. Reset mid-operation: assert rst_n = 0 during continuous reads. Required: ref_data = 0 and ref_valid = 0 immediately (asynchronous). After release and a read of row 2, ref_valid returns after 2 cycles with the pre-reset data intact.
